pong_engine: RTL and testbench
==============================

PONG_ENGINE -- requirements
Module: pong_engine

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 10: coordinate width in grid blocks.
REQ-002 SHALL have parameter PADDLE_LENGTH, default 2: paddle half-length in blocks; paddle covers y-PADDLE_LENGTH..y+PADDLE_LENGTH.
REQ-003 SHALL have parameter TICK_DIV, default 2500000: clk cycles per game tick.
REQ-004 SHALL have parameter SERVE_TICKS, default 20: pause ticks before each serve.
REQ-005 SHALL have parameter WIN_SCORE, default 9: score that ends the game.
REQ-006 SHALL have port clk, input, 1: the single clock of the block.
REQ-007 SHALL have port sysRst, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have ports p1_up, p1_down, p2_up, p2_down, input, 1 each: debounced synchronous paddle buttons.
REQ-009 SHALL have port start, input, 1: level, sampled on ticks; starts a game from IDLE or GAME_OVER.
REQ-010 SHALL have ports ball_x, ball_y, player1_x, player1_y, player2_x, player2_y, output, BIT_WIDTH each: grid coordinates for the graphics driver.
REQ-011 SHALL have ports score1, score2, output, 4 each, and game_over, output, 1.

Function
REQ-012 Grid SHALL be 32x24 blocks, x 0..31, y 0..23; player1_x SHALL be constant 1 and player2_x constant 30.
REQ-013 A tick counter SHALL count 0..TICK_DIV-1 and wrap, asserting a one-cycle tick on the wrap; all game state SHALL update only in tick cycles.
REQ-014 FSM states SHALL be IDLE, SERVE, PLAY, GAME_OVER.
REQ-015 IDLE: ball held at (16,12); on a tick with start=1, clear scores and go to SERVE.
REQ-016 SERVE: ball held at (16,12), serve counter counts ticks; after SERVE_TICKS ticks, go to PLAY.
REQ-017 PLAY: each tick, ball moves by (dx,dy), each of dx, dy in {-1,+1}.
REQ-018 Paddles SHALL move 1 block per tick in IDLE, SERVE and PLAY: up decrements y, down increments y, both or neither pressed means no move.
REQ-019 Paddle y SHALL be clamped to PADDLE_LENGTH..23-PADDLE_LENGTH.
REQ-020 Wall bounce: if ball_y+dy is outside 0..23, dy SHALL negate before the move, so the ball reflects in the same tick.
REQ-021 Paddle hit, player1: ball_x=2, dx=-1 and |ball_y-player1_y|<=PADDLE_LENGTH (pre-move paddle position) SHALL set dx=+1 before the move.
REQ-022 Paddle hit, player2: ball_x=29, dx=+1 and |ball_y-player2_y|<=PADDLE_LENGTH SHALL set dx=-1 before the move.
REQ-023 Wall and paddle reflections in the same tick (corner) SHALL both apply.
REQ-024 Miss, left: ball_x=0 with dx=-1 SHALL increment score2, set dx=-1 (serve toward the conceding player) and dy=+1, and go to SERVE.
REQ-025 Miss, right: ball_x=31 with dx=+1 SHALL increment score1, set dx=+1 and dy=+1, and go to SERVE.
REQ-026 If the incremented score equals WIN_SCORE, the FSM SHALL go to GAME_OVER instead of SERVE.
REQ-027 GAME_OVER: game_over=1, ball and paddles frozen; on a tick with start=1, clear scores and go to SERVE.
REQ-028 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-029 Distance comparisons SHALL use signed arithmetic of BIT_WIDTH+1 bits, so no underflow occurs at y=0.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 While sysRst=0, outputs SHALL be: ball (16,12); player1 (1,12); player2 (30,12); scores 0; game_over 0.
REQ-032 Reset SHALL also force state IDLE, dx=+1, dy=+1, tick counter 0 and serve counter 0.
REQ-033 Reset asserted mid-game SHALL abort the game immediately, with no pending score update.

Structure
REQ-034 Package pong_pkg SHALL hold the state enum, grid size 32/24, centre coordinates and paddle x constants.
REQ-035 Tick generation SHALL be sub-module pong_tick_gen (parameter TICK_DIV; outputs a tick pulse).

Verification (TICK_DIV=4, SERVE_TICKS=2, WIN_SCORE=3)
REQ-036 Reset release, then start=1 for 1 tick -> SERVE; after 2 ticks PLAY; first PLAY tick moves the ball to (17,13).
REQ-037 Ball at (29,10), dx=+1, player2_y=11 -> next tick ball=(28,11) with dx=-1.
REQ-038 Ball at (20,23), dy=+1 -> next tick ball_y=22; ball at (29,0), dx=+1, dy=-1, player2_y=2 -> ball=(28,1).
REQ-039 Ball at (31,5), dx=+1, player2_y=20 -> score1 increments, SERVE, ball (16,12); third such miss -> GAME_OVER, game_over=1.
REQ-040 p1_up held with player1_y=2 -> player1_y stays 2; p1_up and p1_down both held -> player1_y unchanged.
REQ-041 sysRst pulsed low mid-PLAY between ticks -> all outputs return to the REQ-031 values asynchronously, state IDLE.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game engine.
// Holds the FSM state encoding, the 32x24 playfield geometry, the serve
// position and the fixed paddle columns, plus a saturating score helper.
package pong_pkg;

  localparam int unsigned GRID_W   = 32;
  localparam int unsigned GRID_H   = 24;
  localparam int unsigned X_MAX    = GRID_W - 1;
  localparam int unsigned Y_MAX    = GRID_H - 1;
  localparam int unsigned CENTER_X = 16;
  localparam int unsigned CENTER_Y = 12;
  localparam int unsigned P1_X     = 1;
  localparam int unsigned P2_X     = 30;
  // Ball columns directly in front of each paddle, where hits are tested.
  localparam int unsigned P1_HIT_X = P1_X + 1;
  localparam int unsigned P2_HIT_X = P2_X - 1;
  localparam int unsigned SCORE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SERVE     = 2'd1,
    ST_PLAY      = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_e;

  // Score increment that sticks at the limit instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s,
                                                 input logic [SCORE_W-1:0] lim);
    return (s >= lim) ? lim : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Game tick generator: free-running counter 0..TICK_DIV-1 that emits a
// one-cycle registered pulse each time it wraps.
// Ports: clk, rst_n (async active-low), tick_o (one-cycle pulse).
module pong_tick_gen #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  // Wrap detection and next count.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pong_engine.sv
// Pong game engine: ball physics, paddle movement, scoring and game flow on
// a 32x24 block grid, advancing once per game tick.
// Ports: clk, sysRst (async active-low); p1_up/p1_down/p2_up/p2_down paddle
// buttons; start (level, sampled on ticks); ball_x/ball_y and
// player1_x/y, player2_x/y grid coordinates; score1/score2; game_over.
module pong_engine
  import pong_pkg::*;
#(
  parameter int unsigned BIT_WIDTH     = 10,
  parameter int unsigned PADDLE_LENGTH = 2,
  parameter int unsigned TICK_DIV      = 2500000,
  parameter int unsigned SERVE_TICKS   = 20,
  parameter int unsigned WIN_SCORE     = 9
) (
  input  logic                 clk,
  input  logic                 sysRst,
  input  logic                 p1_up,
  input  logic                 p1_down,
  input  logic                 p2_up,
  input  logic                 p2_down,
  input  logic                 start,
  output logic [BIT_WIDTH-1:0] ball_x,
  output logic [BIT_WIDTH-1:0] ball_y,
  output logic [BIT_WIDTH-1:0] player1_x,
  output logic [BIT_WIDTH-1:0] player1_y,
  output logic [BIT_WIDTH-1:0] player2_x,
  output logic [BIT_WIDTH-1:0] player2_y,
  output logic [SCORE_W-1:0]   score1,
  output logic [SCORE_W-1:0]   score2,
  output logic                 game_over
);

  localparam int unsigned SW   = BIT_WIDTH + 1;
  localparam int unsigned SC_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [BIT_WIDTH-1:0] CX      = BIT_WIDTH'(CENTER_X);
  localparam logic [BIT_WIDTH-1:0] CY      = BIT_WIDTH'(CENTER_Y);
  localparam logic [BIT_WIDTH-1:0] XMAX    = BIT_WIDTH'(X_MAX);
  localparam logic [BIT_WIDTH-1:0] HIT1_X  = BIT_WIDTH'(P1_HIT_X);
  localparam logic [BIT_WIDTH-1:0] HIT2_X  = BIT_WIDTH'(P2_HIT_X);
  localparam logic [BIT_WIDTH-1:0] PAD_MIN = BIT_WIDTH'(PADDLE_LENGTH);
  localparam logic [BIT_WIDTH-1:0] PAD_MAX = BIT_WIDTH'(Y_MAX - PADDLE_LENGTH);
  localparam logic [BIT_WIDTH-1:0] ONE     = BIT_WIDTH'(1);

  localparam logic signed [SW-1:0] PL_S    = SW'(PADDLE_LENGTH);
  localparam logic signed [SW-1:0] YMAX_S  = SW'(Y_MAX);
  localparam logic signed [SW-1:0] ONE_S   = SW'(1);

  localparam logic [SC_W-1:0]    SC_LAST = SC_W'((SERVE_TICKS > 0) ? SERVE_TICKS - 1 : 0);
  localparam logic [SCORE_W-1:0] WIN_S   = SCORE_W'(WIN_SCORE);

  state_e                 state_q, state_d;
  logic [BIT_WIDTH-1:0]   ball_x_q, ball_x_d;
  logic [BIT_WIDTH-1:0]   ball_y_q, ball_y_d;
  logic [BIT_WIDTH-1:0]   p1_y_q, p1_y_d;
  logic [BIT_WIDTH-1:0]   p2_y_q, p2_y_d;
  logic                   dx_q, dx_d;   // 1: moving right (+1), 0: left (-1)
  logic                   dy_q, dy_d;   // 1: moving down (+1), 0: up (-1)
  logic [SCORE_W-1:0]     score1_q, score1_d;
  logic [SCORE_W-1:0]     score2_q, score2_d;
  logic [SC_W-1:0]        serve_cnt_q, serve_cnt_d;
  logic                   game_over_q, game_over_d;

  logic                   tick;
  logic                   dx_n, dy_n;
  logic signed [SW-1:0]   next_y_s;
  logic [SCORE_W-1:0]     sc_inc;

  pong_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (sysRst),
    .tick_o (tick)
  );

  // One block of paddle travel, held inside the legal range.
  function automatic logic [BIT_WIDTH-1:0] paddle_step(input logic [BIT_WIDTH-1:0] y,
                                                       input logic up,
                                                       input logic dn);
    logic [BIT_WIDTH-1:0] r;
    r = y;
    if (up && !dn && (y > PAD_MIN)) begin
      r = y - ONE;
    end else if (dn && !up && (y < PAD_MAX)) begin
      r = y + ONE;
    end
    return r;
  endfunction

  // Paddle reach test in signed arithmetic so a ball at y=0 cannot underflow.
  function automatic logic in_reach(input logic [BIT_WIDTH-1:0] by,
                                    input logic [BIT_WIDTH-1:0] py);
    logic signed [SW-1:0] d;
    d = $signed({1'b0, by}) - $signed({1'b0, py});
    return (d <= PL_S) && (d >= -PL_S);
  endfunction

  // Next-state and game logic; everything advances only on a tick.
  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    p1_y_d      = p1_y_q;
    p2_y_d      = p2_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_cnt_d = serve_cnt_q;
    dx_n        = dx_q;
    dy_n        = dy_q;
    next_y_s    = $signed({1'b0, ball_y_q}) + (dy_q ? ONE_S : -ONE_S);
    sc_inc      = '0;

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          p1_y_d   = paddle_step(p1_y_q, p1_up, p1_down);
          p2_y_d   = paddle_step(p2_y_q, p2_up, p2_down);
          ball_x_d = CX;
          ball_y_d = CY;
          if (start) begin
            score1_d    = '0;
            score2_d    = '0;
            serve_cnt_d = '0;
            state_d     = ST_SERVE;
          end
        end

        ST_SERVE: begin
          p1_y_d   = paddle_step(p1_y_q, p1_up, p1_down);
          p2_y_d   = paddle_step(p2_y_q, p2_up, p2_down);
          ball_x_d = CX;
          ball_y_d = CY;
          if (serve_cnt_q == SC_LAST) begin
            serve_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            serve_cnt_d = serve_cnt_q + SC_W'(1);
          end
        end

        ST_PLAY: begin
          p1_y_d = paddle_step(p1_y_q, p1_up, p1_down);
          p2_y_d = paddle_step(p2_y_q, p2_up, p2_down);
          if ((ball_x_q == '0) && !dx_q) begin
            // Left miss: point to player 2, re-serve toward player 1.
            sc_inc      = sat_inc(score2_q, WIN_S);
            score2_d    = sc_inc;
            dx_d        = 1'b0;
            dy_d        = 1'b1;
            ball_x_d    = CX;
            ball_y_d    = CY;
            serve_cnt_d = '0;
            state_d     = (sc_inc == WIN_S) ? ST_GAME_OVER : ST_SERVE;
          end else if ((ball_x_q == XMAX) && dx_q) begin
            // Right miss: point to player 1, re-serve toward player 2.
            sc_inc      = sat_inc(score1_q, WIN_S);
            score1_d    = sc_inc;
            dx_d        = 1'b1;
            dy_d        = 1'b1;
            ball_x_d    = CX;
            ball_y_d    = CY;
            serve_cnt_d = '0;
            state_d     = (sc_inc == WIN_S) ? ST_GAME_OVER : ST_SERVE;
          end else begin
            // Reflections are resolved before the move so the ball never
            // leaves the grid; wall and paddle can both apply in one tick.
            if ((next_y_s < 0) || (next_y_s > YMAX_S)) begin
              dy_n = ~dy_q;
            end
            if ((ball_x_q == HIT1_X) && !dx_q && in_reach(ball_y_q, p1_y_q)) begin
              dx_n = 1'b1;
            end
            if ((ball_x_q == HIT2_X) && dx_q && in_reach(ball_y_q, p2_y_q)) begin
              dx_n = 1'b0;
            end
            dx_d     = dx_n;
            dy_d     = dy_n;
            ball_x_d = dx_n ? ball_x_q + ONE : ball_x_q - ONE;
            ball_y_d = dy_n ? ball_y_q + ONE : ball_y_q - ONE;
          end
        end

        ST_GAME_OVER: begin
          if (start) begin
            score1_d    = '0;
            score2_d    = '0;
            serve_cnt_d = '0;
            state_d     = ST_SERVE;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    game_over_d = (state_d == ST_GAME_OVER);
  end

  always_ff @(posedge clk or negedge sysRst) begin
    if (!sysRst) begin
      state_q     <= ST_IDLE;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      p1_y_q      <= CY;
      p2_y_q      <= CY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_cnt_q <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      p1_y_q      <= p1_y_d;
      p2_y_q      <= p2_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_cnt_q <= serve_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  assign ball_x    = ball_x_q;
  assign ball_y    = ball_y_q;
  assign player1_x = BIT_WIDTH'(P1_X);
  assign player1_y = p1_y_q;
  assign player2_x = BIT_WIDTH'(P2_X);
  assign player2_y = p2_y_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_engine.sv
// Testbench for pong_engine: a tick-level game model predicts every output on
// every cycle; directed scenes pin the model with hand-worked values, then
// random buttons/start/resets exercise the rest.
module tb_pong_engine;

  localparam int BW    = 10;
  localparam int PL    = 2;
  localparam int TDIV  = 4;
  localparam int STK   = 2;
  localparam int WIN   = 3;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_OVER  = 3;

  logic          clk;
  logic          sysRst;
  logic          p1_up, p1_down, p2_up, p2_down, start;
  logic [BW-1:0] ball_x, ball_y, player1_x, player1_y, player2_x, player2_y;
  logic [3:0]    score1, score2;
  logic          game_over;

  pong_engine #(
    .BIT_WIDTH     (BW),
    .PADDLE_LENGTH (PL),
    .TICK_DIV      (TDIV),
    .SERVE_TICKS   (STK),
    .WIN_SCORE     (WIN)
  ) dut (
    .clk       (clk),
    .sysRst    (sysRst),
    .p1_up     (p1_up),
    .p1_down   (p1_down),
    .p2_up     (p2_up),
    .p2_down   (p2_down),
    .start     (start),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .player1_x (player1_x),
    .player1_y (player1_y),
    .player2_x (player2_x),
    .player2_y (player2_y),
    .score1    (score1),
    .score2    (score2),
    .game_over (game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_fail = 0;
  int k      = 0;   // posedges since reset release

  // Game model
  int m_bx, m_by, m_dx, m_dy, m_p1, m_p2, m_s1, m_s2, m_st, m_sc;

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  function automatic int pmove(input int y, input bit up, input bit dn);
    int r;
    r = y;
    if (up && !dn) r = y - 1;
    if (dn && !up) r = y + 1;
    if (r < PL) r = PL;
    if (r > 23 - PL) r = 23 - PL;
    return r;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_bx = 16; m_by = 12; m_dx = 1; m_dy = 1;
    m_p1 = 12; m_p2 = 12; m_s1 = 0; m_s2 = 0;
    m_st = M_IDLE; m_sc = 0;
  endtask

  // One game tick, from the rules of the game.
  task automatic model_tick();
    int np1, np2;
    np1 = pmove(m_p1, p1_up, p1_down);
    np2 = pmove(m_p2, p2_up, p2_down);
    case (m_st)
      M_IDLE: begin
        m_p1 = np1; m_p2 = np2;
        if (start) begin m_s1 = 0; m_s2 = 0; m_sc = 0; m_st = M_SERVE; end
      end
      M_SERVE: begin
        m_p1 = np1; m_p2 = np2;
        m_sc++;
        if (m_sc >= STK) begin m_sc = 0; m_st = M_PLAY; end
      end
      M_PLAY: begin
        if (m_bx == 0 && m_dx < 0) begin
          if (m_s2 < WIN) m_s2++;
          m_dx = -1; m_dy = 1; m_bx = 16; m_by = 12; m_sc = 0;
          m_st = (m_s2 == WIN) ? M_OVER : M_SERVE;
        end else if (m_bx == 31 && m_dx > 0) begin
          if (m_s1 < WIN) m_s1++;
          m_dx = 1; m_dy = 1; m_bx = 16; m_by = 12; m_sc = 0;
          m_st = (m_s1 == WIN) ? M_OVER : M_SERVE;
        end else begin
          if (m_by + m_dy < 0 || m_by + m_dy > 23) m_dy = -m_dy;
          if (m_bx == 2 && m_dx < 0 && iabs(m_by - m_p1) <= PL) m_dx = 1;
          if (m_bx == 29 && m_dx > 0 && iabs(m_by - m_p2) <= PL) m_dx = -1;
          m_bx += m_dx; m_by += m_dy;
        end
        m_p1 = np1; m_p2 = np2;
      end
      default: begin
        if (start) begin m_s1 = 0; m_s2 = 0; m_sc = 0; m_st = M_SERVE; end
      end
    endcase
  endtask

  // One clock: ticks land every TDIV cycles, first one TDIV+1 edges after release.
  task automatic step();
    @(posedge clk);
    k++;
    if (k > TDIV && (k % TDIV) == 1) model_tick();
    @(negedge clk);
    check("ball_x", ball_x, m_bx);
    check("ball_y", ball_y, m_by);
    check("player1_x", player1_x, 1);
    check("player1_y", player1_y, m_p1);
    check("player2_x", player2_x, 30);
    check("player2_y", player2_y, m_p2);
    check("score1", score1, m_s1);
    check("score2", score2, m_s2);
    check("game_over", game_over, (m_st == M_OVER) ? 1 : 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ball_x"}, ball_x, 16);
    check({tag, "_ball_y"}, ball_y, 12);
    check({tag, "_p1_y"}, player1_y, 12);
    check({tag, "_p2_y"}, player2_y, 12);
    check({tag, "_score1"}, score1, 0);
    check({tag, "_score2"}, score2, 0);
    check({tag, "_game_over"}, game_over, 0);
  endtask

  // Asynchronous reset pulse between clock edges, checked before any edge.
  task automatic mid_reset(input string tag);
    #2 sysRst = 1'b0;
    #1 check_reset_values(tag);
    model_reset();
    @(negedge clk);
    sysRst = 1'b1;
    k = 0;
  endtask

  initial begin
    sysRst = 1'b0;
    p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0; start = 0;
    model_reset();
    #12;
    check_reset_values("reset");
    check("reset_p1_x", player1_x, 1);
    check("reset_p2_x", player2_x, 30);
    @(negedge clk);
    sysRst = 1'b1;
    k = 0;

    // Both paddles up to the clamp, then exercise down / both / up.
    p1_up = 1; p2_up = 1;
    steps(48);
    check("p1_clamp_top", player1_y, 2);
    check("p2_clamp_top", player2_y, 2);
    p1_up = 0; p2_up = 0; p1_down = 1;
    steps(12);
    check("p1_down3", player1_y, 5);
    p1_up = 1;
    steps(12);
    check("p1_both_held", player1_y, 5);
    p1_down = 0;
    steps(12);
    check("p1_up_to_clamp", player1_y, 2);
    p1_up = 0;

    // Start, serve for two ticks, first play tick.
    start = 1;
    steps(4);
    start = 0;
    check("serve_hold_x", ball_x, 16);
    steps(8);
    check("serve_hold_y", ball_y, 12);
    steps(4);
    check("first_play_x", ball_x, 17);
    check("first_play_y", ball_y, 13);

    // Ball bounces off the bottom wall and passes player 2 (paddle at y=2).
    steps(60);
    check("miss1_score1", score1, 1);
    check("miss1_ball_x", ball_x, 16);
    steps(72);
    check("miss2_score1", score1, 2);
    steps(72);
    check("miss3_score1", score1, 3);
    check("miss3_game_over", game_over, 1);
    steps(8);
    check("over_frozen_x", ball_x, 16);

    // Restart from game over, then abort mid-play with a reset.
    start = 1;
    steps(4);
    start = 0;
    check("restart_score1", score1, 0);
    check("restart_game_over", game_over, 0);
    steps(8 + 20 + 2);
    mid_reset("midplay");
    steps(16);

    // Random play.
    for (int i = 0; i < 12000; i++) begin
      p1_up   = ($urandom_range(0, 1) == 1);
      p1_down = ($urandom_range(0, 2) == 0);
      p2_up   = ($urandom_range(0, 1) == 1);
      p2_down = ($urandom_range(0, 2) == 0);
      start   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2999) == 0) mid_reset("rand_reset");
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
